// File: rtl/snax_dream_seq_pkg.sv
// Shared types and constants for the DREAM CSR job sequencer.
package snax_dream_seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StPollReq,
        StPollRsp,
        StPollWait
    } seq_state_e;

    localparam int unsigned DefStatusAddr   = 13;
    localparam int unsigned StatusBusyBit   = 0;
    localparam int unsigned DefLaunchOffset = 2;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/snax_dream_csr_sequencer.sv
// Replays a packed job descriptor as CSR writes (launch register last), then polls
// the accelerator status CSR until idle and reports completion with a cycle count.
module snax_dream_csr_sequencer
    import snax_dream_seq_pkg::*;
#(
    parameter int unsigned NumStrCsr  = 10,
    parameter int unsigned NumAccCsr  = DefLaunchOffset + 1,
    parameter int unsigned StatusAddr = DefStatusAddr,
    parameter int unsigned PollGap    = 4,
    parameter int unsigned MaxPolls   = 1024
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [(NumStrCsr+NumAccCsr)*32-1:0]  job_data_i,
    input  logic                                 job_valid_i,
    output logic                                 job_ready_o,
    input  logic                                 abort_i,
    output logic [31:0]                          csr_req_data_o,
    output logic [31:0]                          csr_req_addr_o,
    output logic                                 csr_req_write_o,
    output logic                                 csr_req_valid_o,
    input  logic                                 csr_req_ready_i,
    input  logic [31:0]                          csr_rsp_data_i,
    input  logic                                 csr_rsp_valid_i,
    output logic                                 csr_rsp_ready_o,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic                                 timeout_o,
    output logic                                 aborted_o,
    output logic [31:0]                          cycles_o
);

    localparam int unsigned NumWords = NumStrCsr + NumAccCsr;
    localparam int unsigned IdxW     = cnt_width(NumWords);
    localparam int unsigned PollW    = cnt_width(MaxPolls);
    localparam int unsigned GapW     = cnt_width(PollGap + 1);

    localparam logic [IdxW-1:0]  LastIdx  = IdxW'(NumWords - 1);
    localparam logic [PollW-1:0] LastPoll = PollW'(MaxPolls - 1);
    localparam logic [GapW-1:0]  GapLoad  = GapW'(PollGap);

    seq_state_e         r_state, w_state_next;
    logic [31:0]        r_desc [NumWords];
    logic [IdxW-1:0]    r_idx;
    logic [PollW-1:0]   r_poll;
    logic [GapW-1:0]    r_gap;
    logic [31:0]        r_cnt, r_cycles, w_cnt_inc;
    logic               r_abort_pend, r_done, r_timeout, r_aborted;
    logic               w_abort, w_accept, w_fin, w_fin_done, w_fin_timeout, w_fin_abort;
    logic               w_unused_rsp;

    assign w_unused_rsp = ^csr_rsp_data_i;

    assign w_abort   = r_abort_pend | abort_i;
    assign w_accept  = (r_state == StIdle) && job_valid_i;
    assign w_cnt_inc = (r_cnt == 32'hFFFF_FFFF) ? r_cnt : r_cnt + 32'd1;
    assign w_fin     = w_fin_done | w_fin_timeout | w_fin_abort;

    assign job_ready_o     = (r_state == StIdle);
    assign busy_o          = (r_state != StIdle);
    assign csr_req_valid_o = (r_state == StWrite) || (r_state == StPollReq);
    assign csr_req_write_o = (r_state == StWrite);
    assign csr_rsp_ready_o = (r_state == StPollRsp);
    assign done_o          = r_done;
    assign timeout_o       = r_timeout;
    assign aborted_o       = r_aborted;
    assign cycles_o        = r_cycles;

    always_comb begin
        csr_req_addr_o = '0;
        csr_req_data_o = '0;
        if (r_state == StWrite) begin
            csr_req_addr_o = 32'(r_idx);
            csr_req_data_o = r_desc[r_idx];
        end else if (r_state == StPollReq) begin
            csr_req_addr_o = 32'(StatusAddr);
        end
    end

    // A pending abort is only honoured at a handshake boundary so no request is torn.
    always_comb begin
        w_state_next  = r_state;
        w_fin_done    = 1'b0;
        w_fin_timeout = 1'b0;
        w_fin_abort   = 1'b0;
        case (r_state)
            StIdle: begin
                if (job_valid_i) w_state_next = StWrite;
            end
            StWrite: begin
                if (csr_req_ready_i) begin
                    if (w_abort) begin
                        w_state_next = StIdle;
                        w_fin_abort  = 1'b1;
                    end else if (r_idx == LastIdx) begin
                        w_state_next = StPollReq;
                    end
                end
            end
            StPollReq: begin
                if (csr_req_ready_i) begin
                    if (w_abort) begin
                        w_state_next = StIdle;
                        w_fin_abort  = 1'b1;
                    end else begin
                        w_state_next = StPollRsp;
                    end
                end
            end
            StPollRsp: begin
                if (csr_rsp_valid_i) begin
                    if (w_abort) begin
                        w_state_next = StIdle;
                        w_fin_abort  = 1'b1;
                    end else if (!csr_rsp_data_i[StatusBusyBit]) begin
                        w_state_next = StIdle;
                        w_fin_done   = 1'b1;
                    end else if (r_poll == LastPoll) begin
                        w_state_next  = StIdle;
                        w_fin_timeout = 1'b1;
                    end else begin
                        w_state_next = StPollWait;
                    end
                end
            end
            StPollWait: begin
                if (w_abort) begin
                    w_state_next = StIdle;
                    w_fin_abort  = 1'b1;
                end else if (r_gap == GapW'(1)) begin
                    w_state_next = StPollReq;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= StIdle;
            r_idx        <= '0;
            r_poll       <= '0;
            r_gap        <= '0;
            r_cnt        <= '0;
            r_cycles     <= '0;
            r_abort_pend <= 1'b0;
            r_done       <= 1'b0;
            r_timeout    <= 1'b0;
            r_aborted    <= 1'b0;
            for (int k = 0; k < int'(NumWords); k++) r_desc[k] <= '0;
        end else begin
            r_state      <= w_state_next;
            r_done       <= w_fin_done;
            r_timeout    <= w_fin_timeout;
            r_aborted    <= w_fin_abort;
            r_abort_pend <= (r_state != StIdle) && !w_fin && w_abort;

            if (w_accept) begin
                for (int k = 0; k < int'(NumWords); k++) r_desc[k] <= job_data_i[k*32 +: 32];
                r_idx  <= '0;
                r_poll <= '0;
                r_cnt  <= '0;
            end else if (r_state != StIdle) begin
                r_cnt <= w_cnt_inc;
            end

            if (r_state == StWrite && csr_req_ready_i) r_idx <= r_idx + 1'b1;
            if (r_state == StPollRsp && w_state_next == StPollWait) r_poll <= r_poll + 1'b1;

            if (r_state == StPollRsp) begin
                r_gap <= GapLoad;
            end else if (r_state == StPollWait) begin
                r_gap <= r_gap - 1'b1;
            end

            // Count includes the finishing cycle itself.
            if (w_fin) r_cycles <= w_cnt_inc;
        end
    end

endmodule
